// File: rtl/nn_weight_loader.sv
// nn_weight_loader
// Packs a valid/ready byte stream into WORD_W-bit words and writes them to
// RAM addresses 0..DEPTH-1 in order. The first byte of each word lands in
// bits [BYTE_W-1:0].
// Ports:
//   CLK        clock (rising edge)
//   RST        asynchronous active-low reset
//   start      begins a load run (honoured in IDLE or DONE only)
//   abort      synchronous cancel back to IDLE; highest priority
//   in_data    input byte
//   in_valid   in_data is valid
//   in_ready   a byte is accepted this cycle (LOAD state)
//   mem_addr   RAM write address (held outside WRITE)
//   mem_wdata  RAM write data (held outside WRITE)
//   mem_we     one-cycle write pulse per word
//   busy       high in LOAD and WRITE
//   done       high in DONE
module nn_weight_loader #(
  parameter int WORD_W = 256,
  parameter int BYTE_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              abort,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              busy,
  output logic              done
);

  localparam int LANES = WORD_W / BYTE_W;
  localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_byte_cnt;
  logic [ADDR_W-1:0]   r_word_cnt;
  logic [WORD_W-1:0]   r_asm;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [WORD_W-1:0]   r_mem_wdata;
  logic                w_accept;
  logic                w_last_byte;
  logic                w_last_word;
  logic [WORD_W-1:0]   w_asm_next;

  assign w_accept    = (r_state == S_LOAD) && in_valid;
  assign w_last_byte = (r_byte_cnt == CNT_W'(LANES - 1));
  assign w_last_word = (r_word_cnt == ADDR_W'(DEPTH - 1));

  // Assembly register with the incoming byte merged into its lane; the
  // completed word is taken from here so the output register is loaded on
  // the same edge that accepts the final byte.
  always_comb begin
    w_asm_next = r_asm;
    for (int unsigned j = 0; j < LANES; j++) begin
      if (r_byte_cnt == CNT_W'(j)) begin
        w_asm_next[j*BYTE_W +: BYTE_W] = in_data;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_LOAD;
      S_LOAD:  if (w_accept && w_last_byte) w_state_next = S_WRITE;
      S_WRITE: w_state_next = w_last_word ? S_DONE : S_LOAD;
      S_DONE:  if (start) w_state_next = S_LOAD;
      default: w_state_next = S_IDLE;
    endcase
    if (abort) begin
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_byte_cnt  <= '0;
      r_word_cnt  <= '0;
      r_asm       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (abort) begin
      r_byte_cnt <= '0;
      r_word_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_asm <= w_asm_next;
            if (w_last_byte) begin
              r_byte_cnt  <= '0;
              r_mem_addr  <= r_word_cnt;
              r_mem_wdata <= w_asm_next;
            end else begin
              r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            end
          end
        end
        S_WRITE: begin
          if (!w_last_word) begin
            r_word_cnt <= r_word_cnt + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_LOAD);
  assign mem_we    = (r_state == S_WRITE);
  assign busy      = (r_state == S_LOAD) || (r_state == S_WRITE);
  assign done      = (r_state == S_DONE);
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
